// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and helpers for the tdm_mux link multiplexer
package tdm_pkg;

  localparam int NCH_DEF   = 8;
  localparam int SEL_W_DEF = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef logic [SEL_W_DEF-1:0] ch_idx_t;

  function automatic int idx_inc(input int p, input int n);
    return (p + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority arbiter, scans from i_ptr upward mod NCH
module rr_arbiter #(
  parameter int NCH   = 8,
  parameter int SEL_W = 3
) (
  input  logic [NCH-1:0]   i_req,
  input  logic [SEL_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [NCH-1:0]   o_gnt,
  output logic [SEL_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_k;

  // NCH is a power of two, so the SEL_W-bit add wraps mod NCH for free.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_k       = '0;
    for (int i = 0; i < NCH; i++) begin
      w_k = i_ptr + SEL_W'(i);
      if (i_en && !o_any && i_req[w_k]) begin
        o_any     = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_gnt_idx = w_k;
      end
    end
  end

endmodule

// File: rtl/tdm_mux.sv
// rtl/tdm_mux.sv - NCH-to-1 handshaked link mux driving F/S; TDM_MUX_FIXED_SLOT_EN selects strict slot rotation
module tdm_mux
  import tdm_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int W     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   I_valid,
  input  logic [NCH*W-1:0] I_data,
  output logic [NCH-1:0]   I_ready,
  output logic [W-1:0]     F,
  output logic [SEL_W-1:0] S,
  output logic             O_valid,
  input  logic             O_ready
);

  state_t           r_state;
  logic [W-1:0]     r_f;
  logic [SEL_W-1:0] r_s;
  logic             w_can_load;
  logic [NCH-1:0]   w_req;
  logic [SEL_W-1:0] w_ptr;
  logic [NCH-1:0]   w_gnt;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_any;

  assign w_can_load = (r_state == EMPTY) | (O_valid & O_ready);

`ifdef TDM_MUX_FIXED_SLOT_EN
  logic [SEL_W-1:0] r_slot;
  // Only the current slot may win; the arbiter degenerates to a single-bit check.
  assign w_req = I_valid & (NCH'(1) << r_slot);
  assign w_ptr = r_slot;
`else
  logic [SEL_W-1:0] r_ptr;
  assign w_req = I_valid;
  assign w_ptr = r_ptr;
`endif

  rr_arbiter #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_arb (
    .i_req     (w_req),
    .i_ptr     (w_ptr),
    .i_en      (w_can_load & ~rst),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign I_ready = w_gnt;
  assign F       = r_f;
  assign S       = r_s;
  assign O_valid = (r_state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_f     <= '0;
      r_s     <= '0;
`ifdef TDM_MUX_FIXED_SLOT_EN
      r_slot  <= '0;
`else
      r_ptr   <= '0;
`endif
    end else if (w_can_load) begin
`ifdef TDM_MUX_FIXED_SLOT_EN
      r_slot <= SEL_W'(idx_inc(int'(r_slot), NCH));
`endif
      if (w_any) begin
        r_state <= FULL;
        r_f     <= I_data[w_gnt_idx*W +: W];
        r_s     <= w_gnt_idx;
`ifndef TDM_MUX_FIXED_SLOT_EN
        r_ptr   <= SEL_W'(idx_inc(int'(w_gnt_idx), NCH));
`endif
      end else begin
        r_state <= EMPTY;
      end
    end
  end

endmodule
